// File: rtl/book_level_updater_pkg.sv
// Shared constants for the book level updater: widths, opcodes, FSM states.
// Optional statistics counters are enabled by defining UPDATER_STATS_EN.
`ifndef TOTAL_BITS
`define TOTAL_BITS 32
`endif
`ifndef ADDRESS_INDEX
`define ADDRESS_INDEX 7
`endif
`ifndef BRAM_LATENCY
`define BRAM_LATENCY 2
`endif

package book_level_updater_pkg;
  localparam int QW       = `TOTAL_BITS;
  localparam int AW       = `ADDRESS_INDEX + 1;
  localparam int BRAM_LAT = `BRAM_LATENCY;
  localparam int STAT_W   = 16;

  localparam logic [1:0] OP_ADD    = 2'd0;
  localparam logic [1:0] OP_CANCEL = 2'd1;
  localparam logic [1:0] OP_QUERY  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    MODIFY,
    WR_REQ,
    WR_WAIT,
    RESP
  } state_t;
endpackage

// File: rtl/book_level_updater_alu.sv
// level_qty_alu: saturating add / floored subtract on a level quantity.
// QUERY and opcode 3 pass the old quantity through with flags clear.
module level_qty_alu
  import book_level_updater_pkg::*;
(
  input  logic [1:0]             i_op,
  input  logic [`TOTAL_BITS-1:0] i_old,
  input  logic [`TOTAL_BITS-1:0] i_qty,
  output logic [`TOTAL_BITS-1:0] o_qty,
  output logic                   o_uflow,
  output logic                   o_oflow
);
  logic [`TOTAL_BITS:0] w_sum;
  logic                 w_is_add;
  logic                 w_is_cancel;

  assign w_sum       = {1'b0, i_old} + {1'b0, i_qty};
  assign w_is_add    = (i_op == OP_ADD);
  assign w_is_cancel = (i_op == OP_CANCEL);

  always_comb begin
    o_qty   = i_old;
    o_uflow = 1'b0;
    o_oflow = 1'b0;
    unique case (1'b1)
      w_is_add: begin
        if (w_sum[`TOTAL_BITS]) begin
          o_qty   = '1;
          o_oflow = 1'b1;
        end else begin
          o_qty = w_sum[`TOTAL_BITS-1:0];
        end
      end
      w_is_cancel: begin
        if (i_qty > i_old) begin
          o_qty   = '0;
          o_uflow = 1'b1;
        end else begin
          o_qty = i_old - i_qty;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/book_level_updater.sv
// book_level_updater: read-modify-write of one price level via the memory manager.
// Define UPDATER_STATS_EN to add saturating add/cancel/clamp counters.
module book_level_updater
  import book_level_updater_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     ord_valid,
  output logic                     ord_ready,
  input  logic [1:0]               ord_op,
  input  logic [`ADDRESS_INDEX:0]  ord_addr,
  input  logic [`TOTAL_BITS-1:0]   ord_qty,
  output logic                     mm_start,
  output logic                     mm_is_write,
  output logic [`ADDRESS_INDEX:0]  mm_addr,
  output logic [`TOTAL_BITS-1:0]   mm_wdata,
  input  logic [`TOTAL_BITS-1:0]   mm_rdata,
  input  logic                     mm_valid,
  output logic                     resp_valid,
  output logic [`TOTAL_BITS-1:0]   resp_qty,
  output logic                     resp_uflow,
  output logic                     resp_oflow
`ifdef UPDATER_STATS_EN
  ,
  output logic [STAT_W-1:0]        stat_adds,
  output logic [STAT_W-1:0]        stat_cancels,
  output logic [STAT_W-1:0]        stat_clamps
`endif
);
  state_t                  r_state;
  state_t                  w_next;
  logic [1:0]              r_op;
  logic [`ADDRESS_INDEX:0] r_addr;
  logic [`TOTAL_BITS-1:0]  r_qty;
  logic [`TOTAL_BITS-1:0]  r_old;
  logic [`TOTAL_BITS-1:0]  r_res;
  logic [`TOTAL_BITS-1:0]  r_resp_qty;
  logic                    r_resp_uf;
  logic                    r_resp_of;
  logic                    r_res_uf;
  logic                    r_res_of;
  logic [`TOTAL_BITS-1:0]  w_alu_qty;
  logic                    w_alu_uf;
  logic                    w_alu_of;
  logic                    w_accept;
  logic                    w_to_resp;

  level_qty_alu u_alu (
    .i_op    (r_op),
    .i_old   (r_old),
    .i_qty   (r_qty),
    .o_qty   (w_alu_qty),
    .o_uflow (w_alu_uf),
    .o_oflow (w_alu_of)
  );

  assign w_accept  = ord_valid && ord_ready;
  assign w_to_resp = (w_next == RESP) && (r_state != RESP);

  always_ff @(posedge clk_in) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    ord_ready   = 1'b0;
    mm_start    = 1'b0;
    mm_is_write = 1'b0;
    resp_valid  = 1'b0;
    unique case (r_state)
      IDLE: begin
        ord_ready = !rst;
        if (w_accept) w_next = RD_REQ;
      end
      RD_REQ: begin
        mm_start = 1'b1;
        w_next   = RD_WAIT;
      end
      RD_WAIT: begin
        if (mm_valid) w_next = MODIFY;
      end
      MODIFY: begin
        // opcode bit 1 covers both QUERY and the reserved opcode 3
        w_next = r_op[1] ? RESP : WR_REQ;
      end
      WR_REQ: begin
        mm_start    = 1'b1;
        mm_is_write = 1'b1;
        w_next      = WR_WAIT;
      end
      WR_WAIT: begin
        mm_is_write = 1'b1;
        if (mm_valid) w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_op       <= '0;
      r_addr     <= '0;
      r_qty      <= '0;
      r_old      <= '0;
      r_res      <= '0;
      r_res_uf   <= 1'b0;
      r_res_of   <= 1'b0;
      r_resp_qty <= '0;
      r_resp_uf  <= 1'b0;
      r_resp_of  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= ord_op;
        r_addr <= ord_addr;
        r_qty  <= ord_qty;
      end
      if (r_state == RD_WAIT && mm_valid) r_old <= mm_rdata;
      if (r_state == MODIFY) begin
        r_res    <= w_alu_qty;
        r_res_uf <= w_alu_uf;
        r_res_of <= w_alu_of;
      end
      if (w_to_resp) begin
        r_resp_qty <= (r_state == MODIFY) ? w_alu_qty : r_res;
        r_resp_uf  <= (r_state == MODIFY) ? w_alu_uf  : r_res_uf;
        r_resp_of  <= (r_state == MODIFY) ? w_alu_of  : r_res_of;
      end
    end
  end

  assign mm_addr    = r_addr;
  assign mm_wdata   = r_res;
  assign resp_qty   = r_resp_qty;
  assign resp_uflow = r_resp_uf;
  assign resp_oflow = r_resp_of;

`ifdef UPDATER_STATS_EN
  logic [STAT_W-1:0] r_adds;
  logic [STAT_W-1:0] r_cancels;
  logic [STAT_W-1:0] r_clamps;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_adds    <= '0;
      r_cancels <= '0;
      r_clamps  <= '0;
    end else if (r_state == RESP) begin
      if (r_op == OP_ADD && r_adds != '1)
        r_adds <= r_adds + 1'b1;
      if (r_op == OP_CANCEL && r_cancels != '1)
        r_cancels <= r_cancels + 1'b1;
      if ((r_resp_uf || r_resp_of) && r_clamps != '1)
        r_clamps <= r_clamps + 1'b1;
    end
  end

  assign stat_adds    = r_adds;
  assign stat_cancels = r_cancels;
  assign stat_clamps  = r_clamps;
`endif
endmodule

// File: doc/book_level_updater.md
BOOK_LEVEL_UPDATER -- requirements
Module: book_level_updater

Interface
REQ-001 SHALL have ports: clk_in  input  1  system clock, all logic rising-edge.
REQ-002 SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: ord_valid  input  1 / ord_ready  output  1  order handshake; transfer when both high at a rising edge.
REQ-004 SHALL have ports: ord_op  input  2  opcode, ADD=0, CANCEL=1, QUERY=2, 3 treated as QUERY.
REQ-005 SHALL have ports: ord_addr  input  `ADDRESS_INDEX+1  price-level index; ord_qty  input  `TOTAL_BITS  quantity operand.
REQ-006 SHALL have ports: mm_start, mm_is_write  output  1; mm_addr  output  `ADDRESS_INDEX+1; mm_wdata  output  `TOTAL_BITS; mm_rdata  input  `TOTAL_BITS; mm_valid  input  1. These form the memory-manager request port.
REQ-007 SHALL have ports: resp_valid  output  1  one-cycle completion pulse; resp_qty  output  `TOTAL_BITS  resulting level quantity; resp_uflow, resp_oflow  output  1  clamp flags.

Function
REQ-008 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, MODIFY, WR_REQ, WR_WAIT, RESP.
REQ-009 SHALL assert ord_ready only in IDLE; SHALL register op, addr and qty on accept and then enter RD_REQ.
REQ-010 SHALL, in RD_REQ, pulse mm_start for exactly one cycle with mm_is_write=0, then enter RD_WAIT.
REQ-011 SHALL hold mm_addr and mm_wdata stable from RD_REQ through WR_WAIT, because the memory manager does not latch them.
REQ-012 SHALL, in RD_WAIT, capture mm_rdata on the cycle mm_valid=1 and then enter MODIFY; mm_rdata is ignored in all other cycles.
REQ-013 SHALL, in MODIFY, compute the result as follows:
- ADD: old+qty, saturating at all-ones; sets oflow on saturation.
- CANCEL: old-qty, floored at 0; sets uflow when qty>old.
- QUERY: skips the write and goes to RESP.
REQ-014 SHALL, in WR_REQ, pulse mm_start one cycle with mm_is_write=1 and mm_wdata=result, then wait in WR_WAIT for mm_valid.
REQ-015 SHALL, in RESP, assert resp_valid for one cycle with resp_qty/flags valid, then return to IDLE; resp_qty and flags SHALL hold until the next RESP.
REQ-016 Latency SHALL be as follows:
- ADD/CANCEL: accept -> resp_valid = 2 memory transactions + 4 cycles.
- QUERY: 1 transaction + 3 cycles.
REQ-017 SHALL never assert mm_start outside RD_REQ/WR_REQ, and SHALL never issue a second mm_start before the matching mm_valid.
REQ-018 SHALL ignore an mm_valid arriving in IDLE, MODIFY or RESP; such an mm_valid SHALL NOT change state.
REQ-019 SHALL ignore ord_valid while busy; upstream holds the order until ord_ready.
REQ-020 Back-to-back orders SHALL be supported: a new order may be accepted in the IDLE cycle immediately after RESP.

Reset
REQ-021 rst SHALL force IDLE and drive ord_ready=0 for the reset cycle, then 1; all other outputs SHALL reset to 0 and registered operands SHALL clear.
REQ-022 Reset mid-transaction SHALL abandon it with no write issued afterward; a partially completed read SHALL NOT produce resp_valid.

Configuration
REQ-023 The macro SHALL be UPDATER_STATS_EN.
- When defined: adds outputs stat_adds, stat_cancels, stat_clamps (16 bits each). These are saturating counters, incremented in RESP and cleared by rst.
- When undefined: the ports and logic SHALL be absent and behaviour otherwise identical.

Structure
REQ-024 Opcode constants and stat counter width SHALL live in the shared constants file alongside `TOTAL_BITS, `ADDRESS_INDEX and `BRAM_LATENCY.
REQ-025 Saturating add/sub plus flag generation SHALL be a combinational sub-module, level_qty_alu; the FSM stays in book_level_updater.

Verification
REQ-026 The bench SHALL pair the block with the real memory manager and BRAM model at `BRAM_LATENCY. It SHALL cover:
- Level 8'h10 =0, ADD 100 -> one read and one write of 100; resp_qty=100, flags 0; latency per REQ-016.
- Level 8'h10 =100, CANCEL 40 -> resp_qty=60; subsequent QUERY -> 60 with no write pulse.
- Level 8'h10 =60, CANCEL 100 -> resp_qty=0, resp_uflow=1; memory holds 0.
- Level 8'h20 =32'hFFFFFFF0, ADD 32'h20 -> resp_qty=32'hFFFFFFFF, resp_oflow=1.
- ord_valid held high across 3 queued orders -> ord_ready low while busy, exactly 3 resp_valid pulses, and mm_addr stable during each transaction.
- rst asserted during RD_WAIT of ADD 5 at 8'h30 -> no write, no resp_valid; a later QUERY at 8'h30 returns the original value.
